spi_rxbuf: RTL



---
 rtl/spi_rxbuf_if.sv | 47 ++++
 rtl/spi_rxbuf.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_rxbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_rxbuf_if
// Description : Bundle between the SPI receive core / register-DMA side and
//               the spi_rxbuf post-processing stage. The slave modport is the
//               buffer's view. The master modport is the view of whatever
//               drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_rxbuf_if #(
    parameter int AW = 3
);
    // Frame side, from the receive core and its configuration
    logic [1:0]  df;
    logic        crc_en;
    logic [31:0] spi_rx_data;
    logic        rx_busy;
    logic        rx_num_max_en;
    logic [31:0] rx_crc_data_out;

    // Register / DMA side
    logic        sw_clr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rx_empty;
    logic        rx_full;
    logic [AW:0] rx_cnt;
    logic        ovr_err;
    logic        udr_err;
    logic        crc_err;
    logic        xfer_done;

    modport master (
        output df, crc_en, spi_rx_data, rx_busy, rx_num_max_en,
               rx_crc_data_out, sw_clr, rd_en,
        input  rd_data, rx_empty, rx_full, rx_cnt, ovr_err, udr_err,
               crc_err, xfer_done
    );

    modport slave (
        input  df, crc_en, spi_rx_data, rx_busy, rx_num_max_en,
               rx_crc_data_out, sw_clr, rd_en,
        output rd_data, rx_empty, rx_full, rx_cnt, ovr_err, udr_err,
               crc_err, xfer_done
    );
endinterface
`default_nettype wire

// File: rtl/spi_rxbuf.sv
`default_nettype none
// ============================================================================
// Module      : spi_rxbuf
// Description : Receive post-processing stage. It detects frame completion
//               on the falling edge of rx_busy and masks the data to the
//               frame width. Data frames go into a first-word-fall-through
//               FIFO. An optional trailing CRC frame is checked against the
//               CRC computed by the core. Sticky error flags and an
//               end-of-transfer pulse are also produced.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rxbuf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clk_rx,
    input  logic         spi_rx_rstn,
    spi_rxbuf_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_CRC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    // Keep only the active frame width; the reserved code behaves as 32 bits.
    function automatic logic [31:0] f_mask(input logic [1:0] width, input logic [31:0] value);
        logic [31:0] res;
        unique case (width)
            2'b00:   res = {24'h0, value[7:0]};
            2'b01:   res = {16'h0, value[15:0]};
            default: res = value;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state_q,     w_state_d;
    logic [AW:0] r_wptr_q,      w_wptr_d;
    logic [AW:0] r_rptr_q,      w_rptr_d;
    logic        r_busy_dly_q,  w_busy_dly_d;
    logic [31:0] r_crc_snap_q,  w_crc_snap_d;
    logic        r_ovr_err_q,   w_ovr_err_d;
    logic        r_udr_err_q,   w_udr_err_d;
    logic        r_crc_err_q,   w_crc_err_d;
    logic        r_xfer_done_q, w_xfer_done_d;

    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Derived conditions
    // ------------------------------------------------------------------
    logic        w_fc;
    logic        w_rise;
    logic [31:0] w_data_m;
    logic [31:0] w_crc_m;
    logic        w_empty;
    logic        w_full;
    logic        w_push_req;
    logic        w_pop_ok;
    logic        w_push_ok;
    logic        w_mem_we;

    assign w_fc     = r_busy_dly_q & ~bus.rx_busy;
    assign w_rise   = ~r_busy_dly_q & bus.rx_busy;
    assign w_data_m = f_mask(bus.df, bus.spi_rx_data);
    assign w_crc_m  = f_mask(bus.df, bus.rx_crc_data_out);

    assign w_empty  = (r_wptr_q == r_rptr_q);
    assign w_full   = (r_wptr_q[AW] != r_rptr_q[AW]) &&
                      (r_wptr_q[AW-1:0] == r_rptr_q[AW-1:0]);

    // Every completed frame is data except the one expected to carry the CRC.
    assign w_push_req = w_fc && (r_state_q != ST_CRC);
    assign w_pop_ok   = bus.rd_en && !w_empty;
    // When full, a same-cycle valid pop frees the slot being written.
    assign w_push_ok  = w_push_req && (!w_full || w_pop_ok);
    assign w_mem_we   = w_push_ok && !bus.sw_clr;

    // Next-state logic for pointers, flags and the frame sequencer
    always_comb begin
        w_state_d     = r_state_q;
        w_wptr_d      = r_wptr_q;
        w_rptr_d      = r_rptr_q;
        w_busy_dly_d  = bus.rx_busy;
        w_crc_snap_d  = r_crc_snap_q;
        w_ovr_err_d   = r_ovr_err_q;
        w_udr_err_d   = r_udr_err_q;
        w_crc_err_d   = r_crc_err_q;
        w_xfer_done_d = 1'b0;

        if (bus.sw_clr) begin
            w_state_d    = ST_DATA;
            w_wptr_d     = '0;
            w_rptr_d     = '0;
            w_busy_dly_d = 1'b0;
            w_crc_snap_d = '0;
            w_ovr_err_d  = 1'b0;
            w_udr_err_d  = 1'b0;
            w_crc_err_d  = 1'b0;
        end else begin
            if (w_pop_ok) begin
                w_rptr_d = r_rptr_q + c_ptr_one;
            end
            if (w_push_ok) begin
                w_wptr_d = r_wptr_q + c_ptr_one;
            end
            if (w_push_req && !w_push_ok) begin
                w_ovr_err_d = 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                w_udr_err_d = 1'b1;
            end

            unique case (r_state_q)
                ST_DATA: begin
                    if (w_fc && bus.rx_num_max_en) begin
                        if (bus.crc_en) begin
                            w_crc_snap_d = w_crc_m;
                            w_state_d    = ST_CRC;
                        end else begin
                            w_xfer_done_d = 1'b1;
                            w_state_d     = ST_DONE;
                        end
                    end
                end
                ST_CRC: begin
                    if (w_fc) begin
                        if (w_data_m != r_crc_snap_q) begin
                            w_crc_err_d = 1'b1;
                        end
                        w_xfer_done_d = 1'b1;
                        w_state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A frame finishing here is an ordinary data frame. It was
                    // already pushed through w_push_req.
                    if (w_fc || w_rise) begin
                        w_state_d = ST_DATA;
                    end
                end
                default: begin
                    w_state_d = ST_DATA;
                end
            endcase
        end
    end

    // Register all control state; async reset returns everything to idle
    always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            r_state_q     <= ST_DATA;
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_busy_dly_q  <= 1'b0;
            r_crc_snap_q  <= '0;
            r_ovr_err_q   <= 1'b0;
            r_udr_err_q   <= 1'b0;
            r_crc_err_q   <= 1'b0;
            r_xfer_done_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_busy_dly_q  <= w_busy_dly_d;
            r_crc_snap_q  <= w_crc_snap_d;
            r_ovr_err_q   <= w_ovr_err_d;
            r_udr_err_q   <= w_udr_err_d;
            r_crc_err_q   <= w_crc_err_d;
            r_xfer_done_q <= w_xfer_done_d;
        end
    end

    // FIFO storage; contents past the pointers are never observed, so no reset
    always_ff @(posedge clk_rx) begin
        if (w_mem_we) begin
            r_mem[r_wptr_q[AW-1:0]] <= w_data_m;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_data   = w_empty ? 32'h0 : r_mem[r_rptr_q[AW-1:0]];
    assign bus.rx_empty  = w_empty;
    assign bus.rx_full   = w_full;
    assign bus.rx_cnt    = r_wptr_q - r_rptr_q;
    assign bus.ovr_err   = r_ovr_err_q;
    assign bus.udr_err   = r_udr_err_q;
    assign bus.crc_err   = r_crc_err_q;
    assign bus.xfer_done = r_xfer_done_q;

endmodule
`default_nettype wire
